// File: rtl/avmm_burst_slave_mem.sv
// Avalon-MM burst slave memory: pipelined in-order burst reads
// with bounded outstanding bursts, byte-enabled burst writes.
module avmm_burst_slave_mem #(
  parameter int ADDR_W        = 12,
  parameter int DATA_W        = 32,
  parameter int BURST_W       = 4,
  parameter int MAX_BURST     = 8,
  parameter int READ_LATENCY  = 2,
  parameter int PENDING_DEPTH = 4
) (
  input  logic                clk_clk,
  input  logic                reset_reset_n,
  input  logic [ADDR_W-1:0]   avs_address,
  input  logic [BURST_W-1:0]  avs_burstcount,
  input  logic                avs_read,
  input  logic                avs_write,
  input  logic [DATA_W-1:0]   avs_writedata,
  input  logic [DATA_W/8-1:0] avs_byteenable,
  output logic                avs_waitrequest,
  output logic [DATA_W-1:0]   avs_readdata,
  output logic                avs_readdatavalid
);

  localparam int BE_W  = DATA_W / 8;
  localparam int OFF_W = $clog2(BE_W);
  localparam int WA_W  = ADDR_W - OFF_W;
  localparam int DEPTH = 2 ** WA_W;
  localparam int CNT_W = $clog2(MAX_BURST + 1);
  localparam int PW    = $clog2(PENDING_DEPTH + 1);
  localparam int FW    = (PENDING_DEPTH > 1) ?
                         $clog2(PENDING_DEPTH) : 1;
  localparam int NSTG  = READ_LATENCY - 1;

  typedef struct packed {
    logic [WA_W-1:0]  addr;
    logic [CNT_W-1:0] cnt;
  } rd_cmd_t;

  typedef enum logic {
    W_IDLE,
    W_BURST
  } wstate_t;

  logic [DATA_W-1:0] mem [DEPTH];

  logic [1:0]       rel_q;
  logic             ready;
  logic [WA_W-1:0]  req_wa;
  logic [CNT_W-1:0] req_cnt;
  rd_cmd_t          acc_cmd;

  logic             wr_acc;
  logic             rd_acc;
  logic [WA_W-1:0]  wr_addr;
  wstate_t          ws_q, ws_d;
  logic [WA_W-1:0]  wa_q, wa_d;
  logic [CNT_W-1:0] wrem_q, wrem_d;

  logic             pipe_v;
  rd_cmd_t          pipe_cmd;
  logic [PW-1:0]    pipe_n;

  rd_cmd_t          fifo_q [PENDING_DEPTH];
  logic [FW-1:0]    wr_ptr, rd_ptr;
  logic [PW-1:0]    fifo_n;
  logic [PW-1:0]    pend_cnt;
  logic             pend_full;
  logic             rd_busy;
  logic             pop;
  rd_cmd_t          head;

  logic [CNT_W-1:0] eng_cnt;
  logic [WA_W-1:0]  eng_addr;
  logic             beat;
  logic [WA_W-1:0]  beat_addr;

  // Slave stays stalled for two edges after reset release.
  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) rel_q <= '0;
    else                rel_q <= {rel_q[0], 1'b1};
  end

  assign ready  = rel_q[1];
  assign req_wa = avs_address[ADDR_W-1:OFF_W];

  if (OFF_W > 0) begin : g_lsb
    logic unused_lsb;
    assign unused_lsb = ^avs_address[OFF_W-1:0];
  end

  always_comb begin
    if (avs_burstcount == '0)
      req_cnt = CNT_W'(1);
    else if (32'(avs_burstcount) > MAX_BURST)
      req_cnt = CNT_W'(MAX_BURST);
    else
      req_cnt = CNT_W'(avs_burstcount);
  end

  assign acc_cmd = '{addr: req_wa, cnt: req_cnt};

  assign pend_cnt  = pipe_n + fifo_n;
  assign pend_full = 32'(pend_cnt) >= PENDING_DEPTH;
  assign rd_busy   = (pend_cnt != '0) || (eng_cnt != '0);

  always_comb begin
    ws_d            = ws_q;
    wa_d            = wa_q;
    wrem_d          = wrem_q;
    avs_waitrequest = 1'b1;
    wr_acc          = 1'b0;
    rd_acc          = 1'b0;
    wr_addr         = wa_q;
    if (ready) begin
      unique case (ws_q)
        W_IDLE: begin
          wr_addr = req_wa;
          if (avs_write) begin
            avs_waitrequest = rd_busy;
            wr_acc          = !rd_busy;
          end else if (avs_read) begin
            avs_waitrequest = pend_full;
            rd_acc          = !pend_full;
          end else begin
            avs_waitrequest = 1'b0;
          end
          if (wr_acc) begin
            wa_d   = req_wa + 1'b1;
            wrem_d = req_cnt - 1'b1;
            if (req_cnt != CNT_W'(1)) ws_d = W_BURST;
          end
        end
        W_BURST: begin
          avs_waitrequest = avs_read && !avs_write;
          wr_acc          = avs_write;
          if (wr_acc) begin
            wa_d   = wa_q + 1'b1;
            wrem_d = wrem_q - 1'b1;
            if (wrem_q == CNT_W'(1)) ws_d = W_IDLE;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      ws_q   <= W_IDLE;
      wa_q   <= '0;
      wrem_q <= '0;
    end else begin
      ws_q   <= ws_d;
      wa_q   <= wa_d;
      wrem_q <= wrem_d;
    end
  end

  always_ff @(posedge clk_clk) begin
    if (wr_acc) begin
      for (int b = 0; b < BE_W; b++) begin
        if (avs_byteenable[b])
          mem[wr_addr][b*8 +: 8] <= avs_writedata[b*8 +: 8];
      end
    end
  end

  if (NSTG == 0) begin : g_nopipe
    assign pipe_v   = rd_acc;
    assign pipe_cmd = acc_cmd;
    assign pipe_n   = '0;
  end else begin : g_pipe
    logic [NSTG-1:0] v_q;
    rd_cmd_t         c_q [NSTG];

    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
      if (!reset_reset_n) begin
        v_q <= '0;
        for (int i = 0; i < NSTG; i++) c_q[i] <= '0;
      end else begin
        v_q[0] <= rd_acc;
        c_q[0] <= acc_cmd;
        for (int i = 1; i < NSTG; i++) begin
          v_q[i] <= v_q[i-1];
          c_q[i] <= c_q[i-1];
        end
      end
    end

    always_comb begin
      pipe_n = '0;
      for (int i = 0; i < NSTG; i++)
        pipe_n = pipe_n + PW'(v_q[i]);
    end

    assign pipe_v   = v_q[NSTG-1];
    assign pipe_cmd = c_q[NSTG-1];
  end

  function automatic logic [FW-1:0] ptr_inc(
    input logic [FW-1:0] p
  );
    return (32'(p) == PENDING_DEPTH - 1) ? '0 : p + FW'(1);
  endfunction

  assign head = fifo_q[rd_ptr];
  assign pop  = (eng_cnt == '0) && (fifo_n != '0);

  always_ff @(posedge clk_clk) begin
    if (pipe_v) fifo_q[wr_ptr] <= pipe_cmd;
  end

  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      fifo_n <= '0;
    end else begin
      if (pipe_v) wr_ptr <= ptr_inc(wr_ptr);
      if (pop)    rd_ptr <= ptr_inc(rd_ptr);
      fifo_n <= fifo_n + PW'(pipe_v) - PW'(pop);
    end
  end

  // A new burst starts on the edge after the previous last beat.
  assign beat      = (eng_cnt != '0) || pop;
  assign beat_addr = (eng_cnt != '0) ? eng_addr : head.addr;

  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      eng_cnt           <= '0;
      eng_addr          <= '0;
      avs_readdata      <= '0;
      avs_readdatavalid <= 1'b0;
    end else begin
      avs_readdatavalid <= beat;
      if (beat) begin
        avs_readdata <= mem[beat_addr];
        eng_addr     <= beat_addr + 1'b1;
      end
      if (eng_cnt != '0) eng_cnt <= eng_cnt - 1'b1;
      else if (pop)      eng_cnt <= head.cnt - 1'b1;
    end
  end

endmodule
